// File: rtl/dds_serializer.sv
// Parallel-to-serial stage for the DDS DAC: captures one sample per load strobe and
// shifts it out MSB-first inside an active-low chip-select frame.
module dds_serializer #(
    parameter int W     = 16,
    parameter int SETUP = 1,
    parameter int GAP   = 1
) (
    input  logic         clkI,
    input  logic         rstnI,
    input  logic         loadI,
    input  logic [W-1:0] dataI,
    input  logic         clrI,
    output logic         sdoO,
    output logic         csnO,
    output logic         busyO,
    output logic         doneO,
    output logic         ovfO,
    output logic [1:0]   stateO
);

    localparam int CW   = $clog2(W + 1);
    localparam int PMAX = (SETUP > GAP) ? SETUP : GAP;
    localparam int PW   = $clog2(PMAX + 1);

    localparam logic [CW-1:0] BITS_LAST  = CW'(W);
    localparam logic [PW-1:0] SETUP_LAST = PW'(SETUP);
    localparam logic [PW-1:0] GAP_LAST   = PW'(GAP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t        state;
    logic [W-1:0]  shiftReg;
    logic [CW-1:0] bitCnt;
    logic [PW-1:0] phaseCnt;

    logic lastGap;
    logic acceptLoad;
    logic dropLoad;

    // loadI has no ready: a strobe is taken in IDLE or the final GAP cycle, any other
    // strobe is dropped and flagged on ovfO; the upstream never waits.
    assign lastGap    = (state == S_GAP) && (phaseCnt == GAP_LAST);
    assign acceptLoad = loadI && ((state == S_IDLE) || lastGap);
    assign dropLoad   = loadI && !acceptLoad;

    assign stateO = state;

    always_ff @(posedge clkI or negedge rstnI) begin
        if (!rstnI) begin
            state    <= S_IDLE;
            shiftReg <= '0;
            bitCnt   <= '0;
            phaseCnt <= '0;
            sdoO     <= 1'b0;
            csnO     <= 1'b1;
            busyO    <= 1'b0;
            doneO    <= 1'b0;
        end else begin
            doneO <= 1'b0;
            if (acceptLoad) begin
                state    <= S_SETUP;
                shiftReg <= dataI;
                bitCnt   <= '0;
                phaseCnt <= PW'(1);
                sdoO     <= 1'b0;
                csnO     <= 1'b0;
                busyO    <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        phaseCnt <= '0;
                    end
                    S_SETUP: begin
                        if (phaseCnt == SETUP_LAST) begin
                            state    <= S_SHIFT;
                            phaseCnt <= '0;
                            sdoO     <= shiftReg[W-1];
                            shiftReg <= {shiftReg[W-2:0], 1'b0};
                            bitCnt   <= CW'(1);
                        end else begin
                            phaseCnt <= phaseCnt + PW'(1);
                        end
                    end
                    S_SHIFT: begin
                        // bitCnt equals the number of bits already presented on sdoO
                        if (bitCnt == BITS_LAST) begin
                            state    <= S_GAP;
                            bitCnt   <= '0;
                            phaseCnt <= PW'(1);
                            sdoO     <= 1'b0;
                            csnO     <= 1'b1;
                            busyO    <= 1'b0;
                            doneO    <= 1'b1;
                        end else begin
                            sdoO     <= shiftReg[W-1];
                            shiftReg <= {shiftReg[W-2:0], 1'b0};
                            bitCnt   <= bitCnt + CW'(1);
                        end
                    end
                    S_GAP: begin
                        if (lastGap) begin
                            state    <= S_IDLE;
                            phaseCnt <= '0;
                        end else begin
                            phaseCnt <= phaseCnt + PW'(1);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // A dropped strobe beats a simultaneous clear so no overflow is ever lost.
    always_ff @(posedge clkI or negedge rstnI) begin
        if (!rstnI) begin
            ovfO <= 1'b0;
        end else if (dropLoad) begin
            ovfO <= 1'b1;
        end else if (clrI) begin
            ovfO <= 1'b0;
        end
    end

endmodule
